// File: rtl/nvdla_rt_csb_pipe.sv
// ============================================================================
// Module   : nvdla_rt_csb_pipe
// Brief    : CSB retiming pipe with request backpressure, response delay line
//            and an outstanding-response throttle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nvdla_rt_csb_pipe #(
  parameter int REQ_W       = 63,
  parameter int RESP_W      = 34,
  parameter int REQ_STAGES  = 3,
  parameter int RESP_STAGES = 3,
  parameter int MAX_OUT     = 4,
  parameter int WR_BIT      = 54,
  parameter int NP_BIT      = 55
) (
  input  logic                             nvdla_core_clk,
  input  logic                             nvdla_core_rst,
  input  logic                             req_src_pvld,
  output logic                             req_src_prdy,
  input  logic [REQ_W-1:0]                 req_src_pd,
  output logic                             req_dst_pvld,
  input  logic                             req_dst_prdy,
  output logic [REQ_W-1:0]                 req_dst_pd,
  input  logic                             resp_src_valid,
  input  logic [RESP_W-1:0]                resp_src_pd,
  output logic                             resp_dst_valid,
  output logic [RESP_W-1:0]                resp_dst_pd,
  output logic [$clog2(MAX_OUT+1)-1:0]     outstanding,
  output logic                             err_unexp_resp
);

  localparam int                 c_cnt_w   = $clog2(MAX_OUT + 1);
  localparam logic [c_cnt_w-1:0] c_max_out = c_cnt_w'(MAX_OUT);
  localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);

  logic [REQ_STAGES-1:0]  r_req_vld;
  logic [REQ_W-1:0]       r_req_pd    [REQ_STAGES];
  logic [REQ_STAGES:0]    w_req_rdy;
  logic [REQ_STAGES-1:0]  w_req_up_vld;
  logic [REQ_W-1:0]       w_req_up_pd [REQ_STAGES];

  logic [RESP_STAGES-1:0] r_rsp_vld;
  logic [RESP_W-1:0]      r_rsp_pd    [RESP_STAGES];

  logic [c_cnt_w-1:0]     r_outstanding;
  logic                   r_err;
  logic                   w_accept;
  logic                   w_inc;
  logic                   w_dec;

  // Ready ripples from the slave back toward stage 0 so bubbles collapse.
  always_comb begin
    w_req_rdy             = '0;
    w_req_rdy[REQ_STAGES] = req_dst_prdy;
    for (int i = REQ_STAGES - 1; i >= 0; i--) begin
      w_req_rdy[i] = !r_req_vld[i] || w_req_rdy[i+1];
    end
  end

  assign req_src_prdy = !nvdla_core_rst && w_req_rdy[0] && (r_outstanding != c_max_out);
  assign w_accept     = req_src_pvld && req_src_prdy;

  always_comb begin
    w_req_up_vld    = '0;
    w_req_up_vld[0] = w_accept;
    w_req_up_pd[0]  = req_src_pd;
    for (int i = 1; i < REQ_STAGES; i++) begin
      w_req_up_vld[i] = r_req_vld[i-1];
      w_req_up_pd[i]  = r_req_pd[i-1];
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_req_vld <= '0;
    end else begin
      for (int i = 0; i < REQ_STAGES; i++) begin
        if (w_req_rdy[i]) r_req_vld[i] <= w_req_up_vld[i];
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    for (int i = 0; i < REQ_STAGES; i++) begin
      if (w_req_rdy[i] && w_req_up_vld[i]) r_req_pd[i] <= w_req_up_pd[i];
    end
  end

  assign req_dst_pvld = r_req_vld[REQ_STAGES-1];
  assign req_dst_pd   = r_req_pd[REQ_STAGES-1];

  // Responses cannot be stalled, so this is a plain delay line.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_rsp_vld <= '0;
    end else begin
      r_rsp_vld[0] <= resp_src_valid;
      for (int j = 1; j < RESP_STAGES; j++) begin
        r_rsp_vld[j] <= r_rsp_vld[j-1];
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (resp_src_valid) r_rsp_pd[0] <= resp_src_pd;
    for (int j = 1; j < RESP_STAGES; j++) begin
      if (r_rsp_vld[j-1]) r_rsp_pd[j] <= r_rsp_pd[j-1];
    end
  end

  assign resp_dst_valid = r_rsp_vld[RESP_STAGES-1];
  assign resp_dst_pd    = r_rsp_pd[RESP_STAGES-1];

  // Posted writes never produce a response and so never count.
  assign w_inc = w_accept && (!req_src_pd[WR_BIT] || req_src_pd[NP_BIT]);
  assign w_dec = resp_dst_valid;

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else if (w_inc && !w_dec) begin
      r_outstanding <= r_outstanding + c_one;
    end else if (w_dec && !w_inc) begin
      if (r_outstanding == '0) r_err         <= 1'b1;
      else                     r_outstanding <= r_outstanding - c_one;
    end
  end

  assign outstanding    = r_outstanding;
  assign err_unexp_resp = r_err;

endmodule

`default_nettype wire

// File: tb/tb_nvdla_rt_csb_pipe.sv
// ============================================================================
// Module   : tb_nvdla_rt_csb_pipe
// Brief    : Scoreboard bench for nvdla_rt_csb_pipe (default parameters).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_nvdla_rt_csb_pipe;

  logic        clk;
  logic        rst;
  logic        req_src_pvld;
  logic        req_src_prdy;
  logic [62:0] req_src_pd;
  logic        req_dst_pvld;
  logic        req_dst_prdy;
  logic [62:0] req_dst_pd;
  logic        resp_src_valid;
  logic [33:0] resp_src_pd;
  logic        resp_dst_valid;
  logic [33:0] resp_dst_pd;
  logic [2:0]  outstanding;
  logic        err_unexp_resp;

  int n_checks;
  int n_fail;

  logic [62:0] req_q  [$];
  logic [33:0] resp_q [$];

  nvdla_rt_csb_pipe dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .req_src_pvld   (req_src_pvld),
    .req_src_prdy   (req_src_prdy),
    .req_src_pd     (req_src_pd),
    .req_dst_pvld   (req_dst_pvld),
    .req_dst_prdy   (req_dst_prdy),
    .req_dst_pd     (req_dst_pd),
    .resp_src_valid (resp_src_valid),
    .resp_src_pd    (resp_src_pd),
    .resp_dst_valid (resp_dst_valid),
    .resp_dst_pd    (resp_dst_pd),
    .outstanding    (outstanding),
    .err_unexp_resp (err_unexp_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [62:0] mk(input int i, input bit wr, input bit np);
    logic [62:0] p;
    p = 63'h1A2B_3C4D_5E6F_7081 ^ (63'(i) << 8) ^ 63'(i * 17);
    p[54] = wr;
    p[55] = np;
    return p;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Starts at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_req(input logic [62:0] pd, output int waited);
    bit ok;
    ok     = 1'b0;
    waited = 0;
    req_src_pvld = 1'b1;
    req_src_pd   = pd;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (req_src_prdy) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (ok) req_q.push_back(pd);
    else    chk("req_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    req_src_pvld = 1'b0;
  endtask

  task automatic send_resp(input logic [33:0] pd);
    resp_src_valid = 1'b1;
    resp_src_pd    = pd;
    resp_q.push_back(pd);
    @(posedge clk);
    #1;
    resp_src_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (req_q.size() == 0 && resp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic monitor();
    bit          prev_stall;
    logic [62:0] prev_pd;
    prev_stall = 1'b0;
    prev_pd    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && req_dst_pvld) chk("req_pd_stable", 64'(req_dst_pd), 64'(prev_pd));
        if (req_dst_pvld && req_dst_prdy) begin
          if (req_q.size() == 0) chk("req_unexpected", 64'd1, 64'd0);
          else                   chk("req_pd", 64'(req_dst_pd), 64'(req_q.pop_front()));
        end
        if (resp_dst_valid) begin
          if (resp_q.size() == 0) chk("resp_unexpected", 64'd1, 64'd0);
          else                    chk("resp_pd", 64'(resp_dst_pd), 64'(resp_q.pop_front()));
        end
        prev_stall = req_dst_pvld && !req_dst_prdy;
        prev_pd    = req_dst_pd;
      end
    end
  endtask

  initial begin
    int w;
    int n;
    int wsum;
    int stale;

    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    req_src_pvld   = 1'b0;
    req_src_pd     = '0;
    req_dst_prdy   = 1'b1;
    resp_src_valid = 1'b0;
    resp_src_pd    = '0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_src_prdy", 64'(req_src_prdy), 64'd0);
    chk("rst_dst_pvld", 64'(req_dst_pvld), 64'd0);
    chk("rst_resp_valid", 64'(resp_dst_valid), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err", 64'(err_unexp_resp), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1);

    // Single read: 3-cycle request latency, 3-cycle response latency
    send_req(mk(0, 1'b0, 1'b0), w);
    n = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      n++;
      if (req_dst_pvld) break;
    end
    chk("req_latency", 64'(n), 64'd3);
    chk("read_outstanding", 64'(outstanding), 64'd1);
    step(5);
    send_resp(34'h2_DEAD_BEEF);
    n = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      n++;
      if (resp_dst_valid) break;
    end
    chk("resp_latency", 64'(n), 64'd3);
    @(negedge clk);
    chk("resp_outstanding", 64'(outstanding), 64'd0);
    step(1);

    // Throttle at MAX_OUT
    for (int i = 1; i <= 4; i++) send_req(mk(i, 1'b0, 1'b0), w);
    step(4);
    @(negedge clk);
    chk("thr_outstanding", 64'(outstanding), 64'd4);
    chk("thr_prdy_low", 64'(req_src_prdy), 64'd0);
    step(1);
    send_resp(34'h1_1111_0001);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (resp_dst_valid) break;
    end
    @(negedge clk);
    chk("thr_outstanding_dec", 64'(outstanding), 64'd3);
    chk("thr_prdy_high", 64'(req_src_prdy), 64'd1);
    step(1);
    for (int i = 0; i < 3; i++) send_resp(34'(34'h0_0ABC_0000 + i));
    wait_drain();
    step(2);
    @(negedge clk);
    chk("thr_drained", 64'(outstanding), 64'd0);
    step(1);

    // Backpressure: full pipe with a stalled slave blocks the master
    req_dst_prdy = 1'b0;
    for (int i = 10; i < 13; i++) send_req(mk(i, 1'b1, 1'b0), w);
    @(negedge clk);
    chk("full_prdy_low", 64'(req_src_prdy), 64'd0);
    chk("full_dst_pvld", 64'(req_dst_pvld), 64'd1);
    step(2);
    req_dst_prdy = 1'b1;
    wait_drain();
    step(1);

    // Backpressure: 8 requests with ready toggling each cycle
    begin
      bit done;
      done = 1'b0;
      fork
        begin
          int ww;
          for (int i = 20; i < 28; i++) send_req(mk(i, 1'b1, 1'b0), ww);
          done = 1'b1;
        end
        begin
          for (int t = 0; t < 2000 && !done; t++) begin
            @(posedge clk);
            #1;
            req_dst_prdy = !req_dst_prdy;
          end
        end
      join
    end
    req_dst_prdy = 1'b1;
    wait_drain();
    step(1);

    // Posted writes never count and are never throttled
    wsum = 0;
    for (int i = 30; i < 40; i++) begin
      send_req(mk(i, 1'b1, 1'b0), w);
      wsum += w;
    end
    chk("posted_waits", 64'(wsum), 64'd0);
    wait_drain();
    @(negedge clk);
    chk("posted_outstanding", 64'(outstanding), 64'd0);
    step(1);

    // Non-posted write accepted in the cycle a response exits
    send_req(mk(40, 1'b0, 1'b0), w);
    send_req(mk(41, 1'b0, 1'b0), w);
    step(3);
    send_resp(34'h3_0000_5A5A);
    step(2);
    req_src_pvld = 1'b1;
    req_src_pd   = mk(42, 1'b1, 1'b1);
    req_q.push_back(req_src_pd);
    @(negedge clk);
    chk("simul_resp_valid", 64'(resp_dst_valid), 64'd1);
    chk("simul_prdy", 64'(req_src_prdy), 64'd1);
    @(posedge clk);
    #1;
    req_src_pvld = 1'b0;
    @(negedge clk);
    chk("simul_outstanding", 64'(outstanding), 64'd2);
    step(1);
    send_resp(34'h3_0000_0001);
    send_resp(34'h3_0000_0002);
    wait_drain();
    step(1);
    @(negedge clk);
    chk("simul_drained", 64'(outstanding), 64'd0);
    chk("no_err_yet", 64'(err_unexp_resp), 64'd0);
    step(1);

    // Unexpected response
    send_resp(34'h0_BAD0_0BAD);
    step(5);
    @(negedge clk);
    chk("unexp_err", 64'(err_unexp_resp), 64'd1);
    chk("unexp_outstanding", 64'(outstanding), 64'd0);
    step(6);
    @(negedge clk);
    chk("unexp_err_sticky", 64'(err_unexp_resp), 64'd1);
    step(1);

    // Asynchronous reset with two requests in flight
    send_req(mk(50, 1'b0, 1'b0), w);
    send_req(mk(51, 1'b0, 1'b0), w);
    #2;
    rst = 1'b1;
    #1;
    req_q.delete();
    resp_q.delete();
    chk("arst_dst_pvld", 64'(req_dst_pvld), 64'd0);
    chk("arst_resp_valid", 64'(resp_dst_valid), 64'd0);
    chk("arst_outstanding", 64'(outstanding), 64'd0);
    chk("arst_err", 64'(err_unexp_resp), 64'd0);
    chk("arst_prdy", 64'(req_src_prdy), 64'd0);
    step(2);
    rst   = 1'b0;
    stale = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (req_dst_pvld) stale++;
    end
    chk("arst_no_stale", 64'(stale), 64'd0);
    step(1);
    send_req(mk(60, 1'b0, 1'b0), w);
    step(4);
    @(negedge clk);
    chk("post_rst_outstanding", 64'(outstanding), 64'd1);
    step(1);
    send_resp(34'h1_2345_6789);
    wait_drain();
    step(1);
    @(negedge clk);
    chk("final_outstanding", 64'(outstanding), 64'd0);
    chk("final_req_q", 64'(req_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
